mult_pipe_nxn: RTL and testbench
================================

Name: mult_pipe_nxn

Overview:
- Parametrised N×N shift-add pipelined multiplier with one partial-product row per stage; next generation of the team's 8×8 flow multiplier.
- Adds per-operation signed/unsigned mode, a valid tag travelling with each operand pair, and a global clock-enable for stalling.
- Full throughput: one new operation per enabled cycle.
- Used by datapath and DSP blocks that need a registered product of two N-bit operands.

Parameters:
- WIDTH, 8, operand width N; legal 4..32; product is 2N bits.

Ports:
- CP  in  1  clock, rising edge.
- CLR_  in  1  reset, asynchronous, active-low.
- CE  in  1  clock enable; 0 freezes every pipeline register, including valid bits.
- IN_VALID  in  1  operand pair on A/B/SIGNED is a real operation.
- SIGNED  in  1  1 = two's-complement operands, 0 = unsigned; sampled with A/B.
- A  in  WIDTH  multiplicand.
- B  in  WIDTH  multiplier.
- OUT_VALID  out  1  P carries a new result this cycle.
- P  out  2*WIDTH  product.

Behaviour:
- Reset (CLR_=0, async): all stage registers, valid bits, P and OUT_VALID go to 0 immediately. Reset mid-operation discards all in-flight operations; no stale valid emerges after release.
- Latency is LATENCY = WIDTH+2 enabled cycles from the IN_VALID sample edge to the edge that asserts OUT_VALID. For WIDTH=8, LATENCY=10.
- Stage 0 (input register):
  - Registers IN_VALID, SIGNED, |A| and |B| as WIDTH-bit magnitudes.
  - Registers neg = SIGNED & (A[msb] ^ B[msb]).
  - When SIGNED=0, magnitudes are A and B unchanged.
  - Magnitude of -2^(N-1) is 2^(N-1); it fits in WIDTH bits unsigned, so no overflow.
- Stages 1..WIDTH (row k = stage k):
  - Stage k adds magB[k-1] ? magA : 0 into the running partial sum, aligned at bit k-1.
  - Adder width is WIDTH+1 (sum plus carry); retired low bits pass through unchanged.
  - Each stage carries the delayed magA, magB, neg and valid alongside the partial sum.
- Stage WIDTH+1 (output):
  - P <= neg ? (~sum + 1) : sum, computed mod 2^(2N).
  - OUT_VALID <= final-stage valid.
- P updates only on a cycle where the final-stage valid=1 and CE=1. Otherwise P holds its last result.
- OUT_VALID is a one-cycle pulse per result. It stays high across consecutive results.
- Bubbles (IN_VALID=0) propagate as valid=0. Their datapath contents are don't-care and never reach P.
- CE=0:
  - No register changes.
  - IN_VALID/A/B are ignored, not queued.
  - OUT_VALID and P hold their current values, so a pulse that was high stays high for the whole stall.
- No backpressure beyond CE. The consumer must sample on OUT_VALID & CE.
- Mode mixing: SIGNED may change every cycle. Each operation uses its own sampled mode.
- Zero operands: product is 0. A signed zero result is never negated to a nonzero value (~0+1 wraps to 0).

Decomposition:
- Shared package (mult_pkg):
  - Function latency(WIDTH) = WIDTH+2.
  - Function abs_mag(value, signed) returning a WIDTH-bit magnitude.
  - Stage-record field widths, for reuse by other multiplier variants.
- Sub-module mult_pipe_row:
  - One accumulation stage: registered (WIDTH+1)-bit conditional add plus pass-through of magA, magB, neg, valid and retired low bits.
  - Parameters: WIDTH and ROW index.
  - Instantiated WIDTH times via generate.
  - Shares CP, CLR_ and CE.

Test Plan:
- WIDTH=8, SIGNED=0, A=0xFF, B=0xFF, single pulse -> OUT_VALID exactly 10 cycles later, P=0xFE01, OUT_VALID low all other cycles.
- SIGNED=1: A=0x80, B=0x80 -> P=0x4000; A=0x80, B=0x7F -> P=0xC080; A=0xFF, B=0xFF -> P=0x0001; A=0x00, B=0x80 -> P=0x0000.
- Back-to-back stream of 20 random pairs with alternating SIGNED -> 20 consecutive OUT_VALID cycles, each P matching a reference model, in order.
- Issue 3 ops, drop CE for 4 cycles mid-flight, then raise it -> results delayed by exactly 4 cycles, values correct, P/OUT_VALID frozen during the stall.
- Issue 5 ops, assert CLR_=0 for 1 cycle at cycle 4 -> P=0 and OUT_VALID=0 immediately; no OUT_VALID after release until a new op plus 10 cycles.
- Parameter sweep WIDTH=4 and WIDTH=16: exhaustive (W=4) or 10k random (W=16) signed/unsigned pairs -> all match; latency 6 and 18 respectively.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared helpers for the shift-add multiplier family.
//   latency(width)  : input-sample edge to OUT_VALID edge, in enabled cycles
//   sum_w(width)    : per-row adder width (partial sum plus carry)
//   prod_w(width)   : full product width
//   abs_mag(...)    : magnitude of a (possibly two's-complement) operand
package mult_pkg;

    localparam int unsigned MAX_W = 32;

    function automatic int unsigned latency(input int unsigned width);
        return width + 2;
    endfunction

    function automatic int unsigned sum_w(input int unsigned width);
        return width + 1;
    endfunction

    function automatic int unsigned prod_w(input int unsigned width);
        return 2 * width;
    endfunction

    // Low `width` bits of the result are the magnitude; -2^(w-1) maps to 2^(w-1).
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                                 input logic               is_signed,
                                                 input int unsigned        width);
        logic msb;
        msb = value[5'(width - 1)];
        if (is_signed && msb) begin
            return (~value) + MAX_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/mult_pipe_row.sv
// One accumulation row of the shift-add multiplier.
//   i_cp/i_clr_n/i_ce : clock, async active-low clear, clock enable
//   i_valid/i_neg     : operation tag and result sign, passed through
//   i_mag_a/i_mag_b   : operand magnitudes, passed through
//   i_hi              : upper (still-active) part of the running sum
//   i_lo              : retired low product bits, shifted in from the top
//   o_*               : registered versions for the next row
module mult_pipe_row
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ROW   = 1
) (
    input  logic             i_cp,
    input  logic             i_clr_n,
    input  logic             i_ce,
    input  logic             i_valid,
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_mag_a,
    input  logic [WIDTH-1:0] i_mag_b,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic             o_valid,
    output logic             o_neg,
    output logic [WIDTH-1:0] o_mag_a,
    output logic [WIDTH-1:0] o_mag_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned SUM_W = sum_w(WIDTH);

    logic [WIDTH-1:0] w_addend;
    logic [SUM_W-1:0] w_sum;

    logic             r_valid;
    logic             r_neg;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Partial product for this row, aligned so the sum's LSB is product bit ROW-1.
    assign w_addend = i_mag_b[ROW-1] ? i_mag_a : '0;
    assign w_sum    = SUM_W'(i_hi) + SUM_W'(w_addend);

    // Row register: LSB of the sum retires into the low word, the rest moves down.
    always_ff @(posedge i_cp or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_valid <= 1'b0;
            r_neg   <= 1'b0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (i_ce) begin
            r_valid <= i_valid;
            r_neg   <= i_neg;
            r_mag_a <= i_mag_a;
            r_mag_b <= i_mag_b;
            r_hi    <= w_sum[SUM_W-1:1];
            r_lo    <= WIDTH'({w_sum[0], i_lo} >> 1);
        end
    end

    assign o_valid = r_valid;
    assign o_neg   = r_neg;
    assign o_mag_a = r_mag_a;
    assign o_mag_b = r_mag_b;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;

endmodule

// File: rtl/mult_pipe_nxn.sv
// Pipelined N x N shift-add multiplier, signed/unsigned per operation.
//   CP        : clock, rising edge
//   CLR_      : async active-low reset
//   CE        : clock enable, freezes the whole pipeline when low
//   IN_VALID  : A/B/SIGNED carry a real operation
//   SIGNED    : 1 = two's-complement operands
//   A, B      : operands
//   OUT_VALID : P holds a new result (stays high through a stall)
//   P         : 2*WIDTH-bit product
module mult_pipe_nxn
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               CP,
    input  logic               CLR_,
    input  logic               CE,
    input  logic               IN_VALID,
    input  logic               SIGNED,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               OUT_VALID,
    output logic [2*WIDTH-1:0] P
);

    localparam int unsigned PW = prod_w(WIDTH);

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_neg_in;

    logic             r_valid0;
    logic             r_neg0;
    logic [WIDTH-1:0] r_mag_a0;
    logic [WIDTH-1:0] r_mag_b0;

    // Stage k output at index k; index 0 is the input register.
    logic             w_valid [0:WIDTH];
    logic             w_neg   [0:WIDTH];
    logic [WIDTH-1:0] w_mag_a [0:WIDTH];
    logic [WIDTH-1:0] w_mag_b [0:WIDTH];
    logic [WIDTH-1:0] w_hi    [0:WIDTH];
    logic [WIDTH-1:0] w_lo    [0:WIDTH];

    logic [PW-1:0]    w_prod;
    logic             r_out_valid;
    logic [PW-1:0]    r_p;

    assign w_abs_a  = WIDTH'(abs_mag(MAX_W'(A), SIGNED, WIDTH));
    assign w_abs_b  = WIDTH'(abs_mag(MAX_W'(B), SIGNED, WIDTH));
    assign w_neg_in = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);

    // Input stage: sign-magnitude conversion.
    always_ff @(posedge CP or negedge CLR_) begin
        if (!CLR_) begin
            r_valid0 <= 1'b0;
            r_neg0   <= 1'b0;
            r_mag_a0 <= '0;
            r_mag_b0 <= '0;
        end else if (CE) begin
            r_valid0 <= IN_VALID;
            r_neg0   <= w_neg_in;
            r_mag_a0 <= w_abs_a;
            r_mag_b0 <= w_abs_b;
        end
    end

    assign w_valid[0] = r_valid0;
    assign w_neg[0]   = r_neg0;
    assign w_mag_a[0] = r_mag_a0;
    assign w_mag_b[0] = r_mag_b0;
    assign w_hi[0]    = '0;
    assign w_lo[0]    = '0;

    // One row per multiplier bit.
    for (genvar k = 1; k <= WIDTH; k++) begin : g_row
        mult_pipe_row #(
            .WIDTH (WIDTH),
            .ROW   (k)
        ) u_row (
            .i_cp    (CP),
            .i_clr_n (CLR_),
            .i_ce    (CE),
            .i_valid (w_valid[k-1]),
            .i_neg   (w_neg[k-1]),
            .i_mag_a (w_mag_a[k-1]),
            .i_mag_b (w_mag_b[k-1]),
            .i_hi    (w_hi[k-1]),
            .i_lo    (w_lo[k-1]),
            .o_valid (w_valid[k]),
            .o_neg   (w_neg[k]),
            .o_mag_a (w_mag_a[k]),
            .o_mag_b (w_mag_b[k]),
            .o_hi    (w_hi[k]),
            .o_lo    (w_lo[k])
        );
    end

    assign w_prod = {w_hi[WIDTH], w_lo[WIDTH]};

    // Output stage: restore sign; P only moves when a real result arrives.
    always_ff @(posedge CP or negedge CLR_) begin
        if (!CLR_) begin
            r_out_valid <= 1'b0;
            r_p         <= '0;
        end else if (CE) begin
            r_out_valid <= w_valid[WIDTH];
            if (w_valid[WIDTH]) begin
                r_p <= w_neg[WIDTH] ? (~w_prod + PW'(1)) : w_prod;
            end
        end
    end

    assign OUT_VALID = r_out_valid;
    assign P         = r_p;

endmodule

// File: tb/tb_mult_pipe_nxn.sv
// Self-checking bench for mult_pipe_nxn (WIDTH=8) against a delay-line
// reference that multiplies with plain integer arithmetic.
module tb_mult_pipe_nxn;

    localparam int unsigned W = 8;
    localparam int unsigned L = W + 2;

    logic             CP;
    logic             CLR_;
    logic             CE;
    logic             IN_VALID;
    logic             SIGNED;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             OUT_VALID;
    logic [2*W-1:0]   P;

    int tests = 0;
    int fails = 0;

    // Reference: operations in flight, indexed by enabled edges since sampling.
    logic             mv [L];
    logic [2*W-1:0]   mp [L];
    logic             exp_v;
    logic [2*W-1:0]   exp_p;

    mult_pipe_nxn #(.WIDTH(W)) dut (
        .CP        (CP),
        .CLR_      (CLR_),
        .CE        (CE),
        .IN_VALID  (IN_VALID),
        .SIGNED    (SIGNED),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .P         (P)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    function automatic logic [2*W-1:0] ref_mul(input logic sg, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint av, bv;
        av = longint'(a);
        bv = longint'(b);
        if (sg && a[W-1]) av = av - (longint'(1) << W);
        if (sg && b[W-1]) bv = bv - (longint'(1) << W);
        return (2*W)'(av * bv);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(L); i++) begin
            mv[i] = 1'b0;
            mp[i] = '0;
        end
        exp_v = 1'b0;
        exp_p = '0;
    endtask

    // Drive one cycle, advance the model on an enabled edge, then compare.
    task automatic step(input logic ce, input logic iv, input logic sg,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        CE = ce; IN_VALID = iv; SIGNED = sg; A = a; B = b;
        @(posedge CP);
        if (ce && CLR_) begin
            for (int i = int'(L) - 1; i > 0; i--) begin
                mv[i] = mv[i-1];
                mp[i] = mp[i-1];
            end
            mv[0] = iv;
            mp[0] = ref_mul(sg, a, b);
            exp_v = mv[L-1];
            if (exp_v) exp_p = mp[L-1];
        end
        #1;
        check("out_valid", 64'(OUT_VALID), 64'(exp_v));
        check("p", 64'(P), 64'(exp_p));
    endtask

    task automatic bubble();
        step(1'b1, 1'b0, 1'($urandom), W'($urandom), W'($urandom));
    endtask

    // Single op: edges from its sample edge to OUT_VALID must equal L.
    task automatic run_single(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2*W-1:0] want, input string tag);
        int n;
        step(1'b1, 1'b1, sg, a, b);
        n = 1;
        while (OUT_VALID !== 1'b1 && n < 40) begin
            bubble();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(L));
        check(tag, 64'(P), 64'(want));
        bubble();
        check({tag, "_pulse_end"}, 64'(OUT_VALID), 64'(0));
    endtask

    initial begin
        int n;
        int ov_cnt;
        CLR_ = 1'b0; CE = 1'b0; IN_VALID = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
        model_clear();
        repeat (2) @(posedge CP);
        #1;
        check("reset_out_valid", 64'(OUT_VALID), 64'(0));
        check("reset_p", 64'(P), 64'(0));
        CLR_ = 1'b1;
        repeat (3) bubble();

        // Directed values, including the most-negative operand and zero.
        run_single(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ff_ff");
        run_single(1'b1, 8'h80, 8'h80, 16'h4000, "s_80_80");
        run_single(1'b1, 8'h80, 8'h7F, 16'hC080, "s_80_7f");
        run_single(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_ff_ff");
        run_single(1'b1, 8'h00, 8'h80, 16'h0000, "s_00_80");
        run_single(1'b0, 8'h00, 8'h00, 16'h0000, "u_00_00");

        // Back-to-back stream, alternating mode: 20 consecutive results.
        ov_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'(i % 2), W'($urandom), W'($urandom));
            if (OUT_VALID === 1'b1) ov_cnt++;
        end
        for (int i = 0; i < int'(L) + 2; i++) begin
            bubble();
            if (OUT_VALID === 1'b1) ov_cnt++;
        end
        check("stream_count", 64'(ov_cnt), 64'(20));

        // Stall mid-flight for 4 cycles; ignored inputs during the stall.
        step(1'b1, 1'b1, 1'b1, W'($urandom), W'($urandom));
        n = 1;
        step(1'b1, 1'b1, 1'b0, W'($urandom), W'($urandom)); n++;
        step(1'b1, 1'b1, 1'b1, W'($urandom), W'($urandom)); n++;
        bubble(); n++;
        repeat (4) begin
            step(1'b0, 1'b1, 1'($urandom), W'($urandom), W'($urandom)); n++;
        end
        while (OUT_VALID !== 1'b1 && n < 40) begin
            bubble(); n++;
        end
        check("stall_latency", 64'(n), 64'(L + 4));
        // Stall while a result is presented: pulse and value must hold.
        repeat (3) step(1'b0, 1'b1, 1'($urandom), W'($urandom), W'($urandom));
        repeat (int'(L) + 2) bubble();

        // Async reset mid-flight.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'(i % 2), W'($urandom), W'($urandom));
        #2 CLR_ = 1'b0;
        #1;
        model_clear();
        check("mid_reset_out_valid", 64'(OUT_VALID), 64'(0));
        check("mid_reset_p", 64'(P), 64'(0));
        step(1'b1, 1'b1, 1'b0, W'($urandom), W'($urandom));
        CLR_ = 1'b1;
        repeat (int'(L) + 3) bubble();
        run_single(1'b0, 8'h12, 8'h34, 16'h03A8, "after_reset");

        // Random traffic with random enables, bubbles and modes.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom), W'($urandom), W'($urandom));
        end
        repeat (int'(L) + 2) bubble();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
